// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24-hour BCD clock driven by a clk-cycle prescaler.
//
// Parameters
//   TICK_DIV   clk cycles per one-second tick (2..2^26)
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   en         count enable; low freezes prescaler and digits
//   set_req    one-cycle request to load hours/minutes from set_*
//   set_h_t/o  BCD hour tens/ones to load
//   set_m_t/o  BCD minute tens/ones to load
//   set_ack    one-cycle pulse: load accepted
//   set_err    one-cycle pulse: load rejected (out-of-range value)
//   digit_*    registered BCD time digits hh:mm:ss
//   sec_tick   one-cycle pulse after each seconds advance
//   day_roll   one-cycle pulse after 23:59:59 -> 00:00:00
module bcd_time_counter #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       set_req,
  input  logic [3:0] set_h_t,
  input  logic [3:0] set_h_o,
  input  logic [3:0] set_m_t,
  input  logic [3:0] set_m_o,
  output logic       set_ack,
  output logic       set_err,
  output logic [3:0] digit_h_t,
  output logic [3:0] digit_h_o,
  output logic [3:0] digit_m_t,
  output logic [3:0] digit_m_o,
  output logic [3:0] digit_s_t,
  output logic [3:0] digit_s_o,
  output logic       sec_tick,
  output logic       day_roll
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMax = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [3:0]    h_t_q, h_o_q, m_t_q, m_o_q, s_t_q, s_o_q;
  logic [3:0]    h_t_d, h_o_d, m_t_d, m_o_d, s_t_d, s_o_d;
  logic          sec_tick_q, day_roll_q, set_ack_q, set_err_q;
  logic          tick;
  logic          day_wrap;
  logic          set_valid;

  assign tick = en && (presc_q == PMax);

  assign set_valid = (set_h_t <= 4'd2) &&
                     ((set_h_t == 4'd2) ? (set_h_o <= 4'd3) : (set_h_o <= 4'd9)) &&
                     (set_m_t <= 4'd5) && (set_m_o <= 4'd9);

  // Time one second ahead; computed as a whole so all digits commit on the
  // same edge with no ripple.
  always_comb begin
    h_t_d    = h_t_q;
    h_o_d    = h_o_q;
    m_t_d    = m_t_q;
    m_o_d    = m_o_q;
    s_t_d    = s_t_q;
    s_o_d    = s_o_q;
    day_wrap = 1'b0;
    if (s_o_q != 4'd9) begin
      s_o_d = s_o_q + 4'd1;
    end else begin
      s_o_d = 4'd0;
      if (s_t_q != 4'd5) begin
        s_t_d = s_t_q + 4'd1;
      end else begin
        s_t_d = 4'd0;
        if (m_o_q != 4'd9) begin
          m_o_d = m_o_q + 4'd1;
        end else begin
          m_o_d = 4'd0;
          if (m_t_q != 4'd5) begin
            m_t_d = m_t_q + 4'd1;
          end else begin
            m_t_d = 4'd0;
            if (h_t_q == 4'd2 && h_o_q == 4'd3) begin
              h_t_d    = 4'd0;
              h_o_d    = 4'd0;
              day_wrap = 1'b1;
            end else if (h_o_q == 4'd9) begin
              h_o_d = 4'd0;
              h_t_d = h_t_q + 4'd1;
            end else begin
              h_o_d = h_o_q + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      h_t_q      <= 4'd0;
      h_o_q      <= 4'd0;
      m_t_q      <= 4'd0;
      m_o_q      <= 4'd0;
      s_t_q      <= 4'd0;
      s_o_q      <= 4'd0;
      sec_tick_q <= 1'b0;
      day_roll_q <= 1'b0;
      set_ack_q  <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      day_roll_q <= 1'b0;
      set_ack_q  <= 1'b0;
      set_err_q  <= 1'b0;
      // A set request, accepted or rejected, owns this edge; a coincident
      // tick is dropped.
      if (set_req) begin
        if (set_valid) begin
          h_t_q     <= set_h_t;
          h_o_q     <= set_h_o;
          m_t_q     <= set_m_t;
          m_o_q     <= set_m_o;
          s_t_q     <= 4'd0;
          s_o_q     <= 4'd0;
          presc_q   <= '0;
          set_ack_q <= 1'b1;
        end else begin
          set_err_q <= 1'b1;
        end
      end else if (tick) begin
        presc_q    <= '0;
        h_t_q      <= h_t_d;
        h_o_q      <= h_o_d;
        m_t_q      <= m_t_d;
        m_o_q      <= m_o_d;
        s_t_q      <= s_t_d;
        s_o_q      <= s_o_d;
        sec_tick_q <= 1'b1;
        day_roll_q <= day_wrap;
      end else if (en) begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  assign digit_h_t = h_t_q;
  assign digit_h_o = h_o_q;
  assign digit_m_t = m_t_q;
  assign digit_m_o = m_o_q;
  assign digit_s_t = s_t_q;
  assign digit_s_o = s_o_q;
  assign sec_tick  = sec_tick_q;
  assign day_roll  = day_roll_q;
  assign set_ack   = set_ack_q;
  assign set_err   = set_err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter with TICK_DIV=4. A time-of-day
// model (seconds since midnight) predicts each cycle's outputs; predictions
// are queued when inputs are driven and popped when the DUT is sampled.
module tb_bcd_time_counter;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       set_req;
  logic [3:0] set_h_t, set_h_o, set_m_t, set_m_o;
  logic       set_ack, set_err;
  logic [3:0] digit_h_t, digit_h_o, digit_m_t, digit_m_o, digit_s_t, digit_s_o;
  logic       sec_tick, day_roll;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_tod;
  int m_presc;
  logic [27:0] sb_q[$];

  bcd_time_counter #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .set_req   (set_req),
    .set_h_t   (set_h_t),
    .set_h_o   (set_h_o),
    .set_m_t   (set_m_t),
    .set_m_o   (set_m_o),
    .set_ack   (set_ack),
    .set_err   (set_err),
    .digit_h_t (digit_h_t),
    .digit_h_o (digit_h_o),
    .digit_m_t (digit_m_t),
    .digit_m_o (digit_m_o),
    .digit_s_t (digit_s_t),
    .digit_s_o (digit_s_o),
    .sec_tick  (sec_tick),
    .day_roll  (day_roll)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] dut_vec();
    return {digit_h_t, digit_h_o, digit_m_t, digit_m_o, digit_s_t, digit_s_o,
            sec_tick, day_roll, set_ack, set_err};
  endfunction

  function automatic logic [27:0] pack(input int t, input logic st, input logic dr,
                                       input logic ak, input logic er);
    return {4'(t / 36000), 4'((t / 3600) % 10), 4'(((t / 60) % 60) / 10),
            4'((t / 60) % 10), 4'((t % 60) / 10), 4'(t % 10), st, dr, ak, er};
  endfunction

  // Predict the outcome of the next edge from the current inputs, then sample.
  task automatic step(input string tag);
    logic st, dr, ak, er;
    int   ht, ho, mt, mo;
    st = 1'b0; dr = 1'b0; ak = 1'b0; er = 1'b0;
    ht = int'(set_h_t); ho = int'(set_h_o); mt = int'(set_m_t); mo = int'(set_m_o);
    if (set_req) begin
      if (ht <= 2 && ho <= 9 && !(ht == 2 && ho > 3) && mt <= 5 && mo <= 9) begin
        m_tod   = (ht * 10 + ho) * 3600 + (mt * 10 + mo) * 60;
        m_presc = 0;
        ak      = 1'b1;
      end else begin
        er = 1'b1;
      end
    end else if (en) begin
      if (m_presc == TD - 1) begin
        m_presc = 0;
        m_tod   = (m_tod + 1) % 86400;
        st      = 1'b1;
        dr      = (m_tod == 0);
      end else begin
        m_presc++;
      end
    end
    sb_q.push_back(pack(m_tod, st, dr, ak, er));
    @(posedge clk);
    #1;
    check(tag, {4'd0, dut_vec()}, {4'd0, sb_q.pop_front()});
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_time(input int ht, input int ho, input int mt, input int mo,
                          input string tag);
    set_h_t = 4'(ht); set_h_o = 4'(ho); set_m_t = 4'(mt); set_m_o = 4'(mo);
    set_req = 1'b1;
    step(tag);
    set_req = 1'b0;
  endtask

  // Assert reset between edges and confirm outputs clear before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check(tag, {4'd0, dut_vec()}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    set_req = 1'b0;
    rst     = 1'b0;
    m_tod   = 0;
    m_presc = 0;
    sb_q.delete();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; set_req = 1'b0;
    set_h_t = 4'd0; set_h_o = 4'd0; set_m_t = 4'd0; set_m_o = 4'd0;
    m_tod = 0; m_presc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {4'd0, dut_vec()}, 32'd0);
    rst = 1'b0;

    // First tick after TICK_DIV enabled cycles; then 40 cycles -> 00:00:10
    en = 1'b1;
    run(3, "pre_tick");
    step("first_tick");
    check("s_o_after_4", 32'(digit_s_o), 32'd1);
    check("sec_tick_after_4", 32'(sec_tick), 32'd1);
    run(36, "count40");
    check("s_t_after_40", 32'(digit_s_t), 32'd1);
    check("s_o_after_40", 32'(digit_s_o), 32'd0);

    // Set validation
    set_time(2, 4, 0, 0, "set_bad_24");
    check("bad24_err", 32'(set_err), 32'd1);
    check("bad24_time", {8'd0, digit_h_t, digit_h_o, digit_m_t, digit_m_o, digit_s_t,
                         digit_s_o}, 32'h000010);
    set_time(1, 9, 6, 0, "set_bad_m60");
    check("badm60_err", 32'(set_err), 32'd1);
    set_time(1, 9, 5, 9, "set_ok_1959");
    check("ok_ack", 32'(set_ack), 32'd1);
    check("ok_time", {8'd0, digit_h_t, digit_h_o, digit_m_t, digit_m_o, digit_s_t,
                      digit_s_o}, 32'h195900);

    // Day rollover
    set_time(2, 3, 5, 9, "set_2359");
    run(59 * TD, "to_235959");
    check("at_235959", {8'd0, digit_h_t, digit_h_o, digit_m_t, digit_m_o, digit_s_t,
                        digit_s_o}, 32'h235959);
    run(TD, "rollover");
    check("roll_digits", {8'd0, digit_h_t, digit_h_o, digit_m_t, digit_m_o, digit_s_t,
                          digit_s_o}, 32'h000000);
    check("roll_pulses", {30'd0, sec_tick, day_roll}, 32'd3);

    // Set on the prescaler-wrap cycle wins over the tick
    run(1, "pre_wrap");
    for (int i = 0; i < int'(TD) && m_presc != int'(TD) - 1; i++) step("seek_wrap");
    set_time(1, 2, 3, 4, "set_on_wrap");
    check("wrap_no_tick", 32'(sec_tick), 32'd0);
    run(TD - 1, "post_set");
    check("post_set_quiet", 32'(sec_tick), 32'd0);
    step("post_set_tick");
    check("post_set_tick4", 32'(sec_tick), 32'd1);

    // Enable freeze mid-second
    run(2, "mid_second");
    en = 1'b0;
    run(10, "frozen");
    check("frozen_time", {8'd0, digit_h_t, digit_h_o, digit_m_t, digit_m_o, digit_s_t,
                          digit_s_o}, 32'h123401);
    en = 1'b1;
    run(TD, "resume");

    // Held set_req: one response per cycle
    set_h_t = 4'd0; set_h_o = 4'd5; set_m_t = 4'd0; set_m_o = 4'd0;
    set_req = 1'b1;
    step("held_set0");
    set_h_t = 4'd3;
    step("held_set1");
    set_h_t = 4'd1;
    step("held_set2");
    set_req = 1'b0;
    en = 1'b0;
    set_time(0, 7, 0, 0, "set_while_disabled");
    en = 1'b1;

    // Async reset at 12:34:56, mid-second, with a set pending
    set_time(1, 2, 3, 4, "set_1234");
    run(56 * TD, "to_123456");
    check("at_123456", {8'd0, digit_h_t, digit_h_o, digit_m_t, digit_m_o, digit_s_t,
                        digit_s_o}, 32'h123456);
    run(2, "mid_sec");
    set_h_t = 4'd0; set_h_o = 4'd9; set_m_t = 4'd0; set_m_o = 4'd0;
    set_req = 1'b1;
    async_reset("async_rst_zero");
    run(TD, "post_rst");

    // Random mix
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      set_req = ($urandom_range(0, 15) == 0);
      set_h_t = 4'($urandom_range(0, 3));
      set_h_o = 4'($urandom_range(0, 11));
      set_m_t = 4'($urandom_range(0, 7));
      set_m_o = 4'($urandom_range(0, 10));
      step("random");
    end
    set_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
